// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default parameter
// values and the next-PC source select used by the priority mux.
package pc_pkg;

  localparam int unsigned DEF_ADDR_W    = 72;
  localparam int unsigned DEF_STRIDE    = 72;
  localparam int unsigned DEF_OFF_W     = 68;
  localparam int unsigned DEF_RAS_DEPTH = 8;
  localparam int unsigned DEF_RESET_VEC = 0;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  // Next-PC source. Nothing is honoured until the PC is valid; after that
  // ret > call > jump > branch > increment, and losing requests are dropped.
  function automatic pc_sel_e pc_select(input logic valid, input logic ret,
                                        input logic call, input logic jump,
                                        input logic br, input logic adv);
    if (!valid) return SEL_HOLD;
    if (ret)    return SEL_RET;
    if (call)   return SEL_CALL;
    if (jump)   return SEL_JMP;
    if (br)     return SEL_BR;
    if (adv)    return SEL_INC;
    return SEL_HOLD;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the decode/branch unit, the fetch port and
// the PC sequencer.
//   master : drives fetch_ready, stall and the redirect requests; observes the PC
//   slave  : the sequencer itself
interface pc_sequencer_if import pc_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned OFF_W  = DEF_OFF_W
);
  logic              fetch_ready;
  logic              stall;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_en;
  logic [OFF_W-1:0]  branch_offset;
  logic              call_en;
  logic              ret_en;
  logic [ADDR_W-1:0] pc_out;
  logic              pc_valid;
  logic              redirect;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output fetch_ready, stall, jump_en, jump_target, branch_en, branch_offset,
           call_en, ret_en,
    input  pc_out, pc_valid, redirect, ras_empty, ras_full, ras_overflow,
           ras_underflow
  );

  modport slave (
    input  fetch_ready, stall, jump_en, jump_target, branch_en, branch_offset,
           call_en, ret_en,
    output pc_out, pc_valid, redirect, ras_empty, ras_full, ras_overflow,
           ras_underflow
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return address stack. A push while full overwrites the oldest
// entry; a pop while empty is ignored (the caller decides what to fetch).
//   clk, reset : clock, synchronous active-low reset
//   i_push     : write i_din as the new top entry
//   i_pop      : discard the top entry (never asserted together with i_push)
//   i_din      : return address to push
//   o_top      : current top entry (meaningful only when !o_empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module pc_ras #(
  parameter int unsigned W     = 72,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;   // next slot to write; top is the slot below it
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_rd_ptr;

  // Power-of-two depth lets the pointer wrap naturally, which is what makes
  // a push while full land on the oldest entry.
  assign w_rd_ptr = r_wr_ptr - PTR_W'(1);
  assign o_top    = r_mem[w_rd_ptr];
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);

  // NOTE: the storage array has no reset; validity is tracked by r_count, so
  // clearing the entries would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (reset && i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (!o_full) r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_wr_ptr <= w_rd_ptr;
      r_count  <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the fetch front end: sequential increment, stall,
// absolute jump, PC-relative branch, and call/return via pc_ras.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-low reset, overrides every request
//   bus   : pc_sequencer_if.slave (requests in; pc_out, pc_valid, redirect
//           and RAS status out)
module pc_sequencer import pc_pkg::*; #(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DEF_STRIDE),
  parameter int unsigned       OFF_W     = DEF_OFF_W,
  parameter int unsigned       RAS_DEPTH = DEF_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  localparam int unsigned EXT_W = ADDR_W - OFF_W;

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_redirect;
  logic              r_overflow;
  logic              r_underflow;

  pc_sel_e           w_sel;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_br_pc;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_full;
  logic              w_ras_empty;
  logic              w_push;
  logic              w_pop;

  assign w_sel = pc_select(r_valid, bus.ret_en, bus.call_en, bus.jump_en,
                           bus.branch_en, bus.fetch_ready && !bus.stall);

  // Sequential address doubles as the return address pushed on a call.
  assign w_seq_pc = r_pc + STRIDE;
  assign w_br_pc  = r_pc + {{EXT_W{bus.branch_offset[OFF_W-1]}}, bus.branch_offset};
  assign w_push   = (w_sel == SEL_CALL);
  assign w_pop    = (w_sel == SEL_RET);

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_seq_pc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );

  // NOTE: default assigned before the case so every path drives w_pc_nxt and
  // no latch is inferred.
  always_comb begin
    w_pc_nxt = r_pc;
    unique case (w_sel)
      SEL_INC:  w_pc_nxt = w_seq_pc;
      SEL_BR:   w_pc_nxt = w_br_pc;
      SEL_JMP:  w_pc_nxt = bus.jump_target;
      SEL_CALL: w_pc_nxt = bus.jump_target;
      SEL_RET:  w_pc_nxt = w_ras_empty ? RESET_VEC : w_ras_top;
      default:  w_pc_nxt = r_pc;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc        <= RESET_VEC;
      r_valid     <= 1'b0;
      r_redirect  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_valid    <= 1'b1;
      r_redirect <= (w_sel inside {SEL_BR, SEL_JMP, SEL_CALL, SEL_RET});
      if (w_push && w_ras_full)  r_overflow  <= 1'b1;
      if (w_pop  && w_ras_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.pc_out        = r_pc;
  assign bus.pc_valid      = r_valid;
  assign bus.redirect      = r_redirect;
  assign bus.ras_empty     = w_ras_empty;
  assign bus.ras_full      = w_ras_full;
  assign bus.ras_overflow  = r_overflow;
  assign bus.ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. A reference model computes the
// post-edge state for the inputs applied each cycle; that expectation is
// queued and compared against the DUT one edge later.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned AW    = 72;
  localparam int unsigned OW    = 68;
  localparam int unsigned DEPTH = 8;
  localparam logic [AW-1:0] STR  = 72'd72;
  localparam logic [AW-1:0] RVEC = 72'd0;

  typedef struct {
    logic [AW-1:0] pc;
    logic          valid;
    logic          redirect;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic clk;
  logic reset;

  pc_sequencer_if #(.ADDR_W(AW), .OFF_W(OW)) bus ();

  pc_sequencer #(
    .ADDR_W    (AW),
    .STRIDE    (STR),
    .OFF_W     (OW),
    .RAS_DEPTH (DEPTH),
    .RESET_VEC (RVEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  exp_t          exp_q[$];
  logic [AW-1:0] m_stk[$];   // back = top of stack
  logic [AW-1:0] m_pc;
  logic          m_valid, m_red, m_ovf, m_unf;

  task automatic check(input string tag, input logic [AW-1:0] obs,
                       input logic [AW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs now applied.
  task automatic model_edge();
    logic signed [AW-1:0] sx;
    if (!reset) begin
      m_pc = RVEC; m_valid = 1'b0; m_red = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0;
      m_stk.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_red   = 1'b0;
    end else if (bus.ret_en) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = RVEC; m_unf = 1'b1; end
      m_red = 1'b1;
    end else if (bus.call_en) begin
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back(m_pc + STR);
      m_pc  = bus.jump_target;
      m_red = 1'b1;
    end else if (bus.jump_en) begin
      m_pc  = bus.jump_target;
      m_red = 1'b1;
    end else if (bus.branch_en) begin
      sx    = $signed(bus.branch_offset);
      m_pc  = m_pc + sx;
      m_red = 1'b1;
    end else begin
      if (bus.fetch_ready && !bus.stall) m_pc = m_pc + STR;
      m_red = 1'b0;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.pc = m_pc; e.valid = m_valid; e.redirect = m_red;
    e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == DEPTH);
    e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("pc_out",        bus.pc_out,        e.pc);
    check("pc_valid",      AW'(bus.pc_valid),      AW'(e.valid));
    check("redirect",      AW'(bus.redirect),      AW'(e.redirect));
    check("ras_empty",     AW'(bus.ras_empty),     AW'(e.empty));
    check("ras_full",      AW'(bus.ras_full),      AW'(e.full));
    check("ras_overflow",  AW'(bus.ras_overflow),  AW'(e.ovf));
    check("ras_underflow", AW'(bus.ras_underflow), AW'(e.unf));
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.branch_en = 1'b0;
    bus.call_en = 1'b0; bus.ret_en = 1'b0;
    bus.jump_target = '0; bus.branch_offset = '0;
  endtask

  task automatic do_jump(input logic [AW-1:0] tgt);
    idle(); bus.jump_en = 1'b1; bus.jump_target = tgt; step(); idle();
  endtask

  initial begin
    logic [AW-1:0] tgt;
    m_pc = RVEC; m_valid = 1'b0; m_red = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1'b0;
    idle();
    bus.fetch_ready = 1'b1;
    #1;

    // Reset held two cycles, then sequential fetch 0, 72, 144.
    step(); step();
    check("rst_valid", AW'(bus.pc_valid), '0);
    reset = 1'b1;
    step();
    check("first_pc", bus.pc_out, 72'd0);
    step(); step();
    check("seq_144", bus.pc_out, 72'd144);

    // Hold on fetch_ready low and on stall, then resume.
    bus.fetch_ready = 1'b0; step(); step();
    bus.fetch_ready = 1'b1; bus.stall = 1'b1; step();
    check("stall_hold", bus.pc_out, 72'd144);
    bus.stall = 1'b0; step();
    check("resume_216", bus.pc_out, 72'd216);

    // Backward branch, then branch that wraps below zero.
    do_jump(72'd720);
    bus.branch_en = 1'b1; bus.branch_offset = -68'sd144; step(); idle();
    check("br_576", bus.pc_out, 72'd576);
    bus.fetch_ready = 1'b0; step(); bus.fetch_ready = 1'b1;
    do_jump(72'd0);
    bus.branch_en = 1'b1; bus.branch_offset = -68'sd72; step(); idle();
    tgt = '0; tgt = tgt - 72'd72;
    check("br_wrap", bus.pc_out, tgt);

    // Single call/return.
    do_jump(72'd72);
    bus.call_en = 1'b1; bus.jump_target = 72'd1000; step(); idle();
    check("call_1000", bus.pc_out, 72'd1000);
    bus.ret_en = 1'b1; step(); idle();
    check("ret_144", bus.pc_out, 72'd144);

    // Nine nested calls overflow the 8-deep stack; nine returns underflow.
    do_jump(72'd4096);
    for (int i = 1; i <= 9; i++) begin
      bus.call_en = 1'b1; bus.jump_target = 72'd8192 + AW'(i * 256); step();
    end
    idle();
    check("ovf_set", AW'(bus.ras_overflow), 72'd1);
    for (int i = 1; i <= 9; i++) begin
      bus.ret_en = 1'b1; step();
      if (i == 1) check("ret_first", bus.pc_out, 72'd8192 + 72'd2048 + 72'd72);
    end
    idle();
    check("unf_pc", bus.pc_out, RVEC);
    check("unf_set", AW'(bus.ras_underflow), 72'd1);

    // Simultaneous ret/jump/branch: ret wins, nothing pushed.
    do_jump(72'd428);
    bus.call_en = 1'b1; bus.jump_target = 72'd3000; step(); idle();
    bus.ret_en = 1'b1; bus.jump_en = 1'b1; bus.jump_target = 72'd7777;
    bus.branch_en = 1'b1; bus.branch_offset = 68'd64; step(); idle();
    check("prio_ret", bus.pc_out, 72'd500);
    check("prio_nopush", AW'(bus.ras_empty), 72'd1);

    // Reset mid-sequence with requests pending; a jump during the first
    // cycle after release must be ignored.
    step();
    bus.jump_en = 1'b1; bus.jump_target = 72'd999; reset = 1'b0; step();
    check("mid_rst_pc", bus.pc_out, RVEC);
    reset = 1'b1; step();
    check("pre_valid_ignored", bus.pc_out, RVEC);
    idle();

    // Random mix of requests against the model.
    for (int i = 0; i < 400; i++) begin
      bus.fetch_ready   = ($urandom_range(0, 3) != 0);
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.ret_en        = ($urandom_range(0, 7) == 0);
      bus.call_en       = ($urandom_range(0, 5) == 0);
      bus.jump_en       = ($urandom_range(0, 9) == 0);
      bus.branch_en     = ($urandom_range(0, 6) == 0);
      bus.jump_target   = AW'({$urandom(), $urandom(), $urandom()});
      bus.branch_offset = OW'({$urandom(), $urandom(), $urandom()});
      reset             = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
